// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus bundle: ALU and LSU write requests, decode source ports and the register-file write port.
// The master side drives the requests; the slave side (the arbiter) drives ready, hazard and the write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_N = 32
);
  logic              alu_valid;
  logic [4:0]        alu_rd_addr;
  logic [DATA_N-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_rd_addr;
  logic [DATA_N-1:0] lsu_data;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic              hazard;
  logic              rd_wren;
  logic [4:0]        rd_addr;
  logic [DATA_N-1:0] rd_data;

  modport master (
    output alu_valid, alu_rd_addr, alu_data,
    output lsu_valid, lsu_rd_addr, lsu_data,
    output rs1_addr, rs2_addr,
    input  lsu_ready, hazard, rd_wren, rd_addr, rd_data
  );

  modport slave (
    input  alu_valid, alu_rd_addr, alu_data,
    input  lsu_valid, lsu_rd_addr, lsu_data,
    input  rs1_addr, rs2_addr,
    output lsu_ready, hazard, rd_wren, rd_addr, rd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU wins every cycle, LSU results queue in a DEPTH-entry FIFO.
// Latency 1 for ALU (and for LSU bypass under WB_LSU_BYPASS_EN), LSU >= 2 otherwise; LSU stalls via lsu_ready when full.
module regfile_wb_arbiter #(
  parameter int DATA_N = 32,
  parameter int DEPTH  = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              rd_wren_q, rd_wren_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [DATA_N-1:0] rd_data_q, rd_data_d;
  logic [4:0]        mem_addr_q [DEPTH];
  logic [DATA_N-1:0] mem_data_q [DEPTH];

  logic lsu_ready;
  logic alu_wr, lsu_acc, lsu_keep, pop, push, bypass;
  logic hazard;

  // Ready is gated by reset so the LSU never hands off a transfer that the reset edge would drop.
  assign lsu_ready    = ~rst_i & (count_q < FULL_CNT);
  assign wb.lsu_ready = lsu_ready;
  assign wb.rd_wren   = rd_wren_q;
  assign wb.rd_addr   = rd_addr_q;
  assign wb.rd_data   = rd_data_q;
  assign wb.hazard    = hazard;

  always_comb begin
    alu_wr   = wb.alu_valid & (wb.alu_rd_addr != 5'd0);
    lsu_acc  = wb.lsu_valid & lsu_ready;
    lsu_keep = lsu_acc & (wb.lsu_rd_addr != 5'd0);
    pop      = ~alu_wr & (count_q != '0);
`ifdef WB_LSU_BYPASS_EN
    bypass   = lsu_keep & ~alu_wr & (count_q == '0);
`else
    bypass   = 1'b0;
`endif
    push     = lsu_keep & ~bypass;

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    rd_wren_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (alu_wr) begin
      rd_wren_d = 1'b1;
      rd_addr_d = wb.alu_rd_addr;
      rd_data_d = wb.alu_data;
    end else if (pop) begin
      rd_wren_d = 1'b1;
      rd_addr_d = mem_addr_q[rd_ptr_q];
      rd_data_d = mem_data_q[rd_ptr_q];
    end else if (bypass) begin
      rd_wren_d = 1'b1;
      rd_addr_d = wb.lsu_rd_addr;
      rd_data_d = wb.lsu_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - rd_ptr_q} < count_q) begin
        if ((wb.rs1_addr != 5'd0) && (wb.rs1_addr == mem_addr_q[i])) hazard = 1'b1;
        if ((wb.rs2_addr != 5'd0) && (wb.rs2_addr == mem_addr_q[i])) hazard = 1'b1;
      end
    end
    if (rd_wren_q) begin
      if ((wb.rs1_addr != 5'd0) && (wb.rs1_addr == rd_addr_q)) hazard = 1'b1;
      if ((wb.rs2_addr != 5'd0) && (wb.rs2_addr == rd_addr_q)) hazard = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_wren_q <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_addr_q[wr_ptr_q] <= wb.lsu_rd_addr;
      mem_data_q[wr_ptr_q] <= wb.lsu_data;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (default build, FIFO path, DEPTH=4) with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_N(32)) wb ();

  regfile_wb_arbiter #(.DATA_N(32), .DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.alu_valid   = 1'b0;
    wb.alu_rd_addr = 5'd0;
    wb.alu_data    = 32'd0;
    wb.lsu_valid   = 1'b0;
    wb.lsu_rd_addr = 5'd0;
    wb.lsu_data    = 32'd0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    wb.alu_valid   = 1'b1;
    wb.alu_rd_addr = a;
    wb.alu_data    = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    wb.lsu_valid   = 1'b1;
    wb.lsu_rd_addr = a;
    wb.lsu_data    = d;
  endtask

  task automatic exp_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wren"}, 64'(wb.rd_wren), 64'd1);
    chk({tag, "_addr"}, 64'(wb.rd_addr), 64'(a));
    chk({tag, "_data"}, 64'(wb.rd_data), 64'(d));
  endtask

  logic [4:0]  full_addr [4];
  logic [31:0] full_data [4];

  initial begin
    idle();
    wb.rs1_addr = 5'd0;
    wb.rs2_addr = 5'd0;
    full_addr[0] = 5'd20; full_data[0] = 32'h100;
    full_addr[1] = 5'd21; full_data[1] = 32'h101;
    full_addr[2] = 5'd20; full_data[2] = 32'h102;
    full_addr[3] = 5'd23; full_data[3] = 32'h103;

    // Reset state
    step();
    step();
    chk("rst_ready", 64'(wb.lsu_ready), 64'd0);
    chk("rst_wren", 64'(wb.rd_wren), 64'd0);
    chk("rst_addr", 64'(wb.rd_addr), 64'd0);
    chk("rst_data", 64'(wb.rd_data), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(wb.lsu_ready), 64'd1);
    chk("post_rst_hazard", 64'(wb.hazard), 64'd0);

    // ALU alone, then hold
    alu(5'd5, 32'hDEADBEEF);
    step();
    exp_wr("alu", 5'd5, 32'hDEADBEEF);
    idle();
    step();
    chk("alu_hold_wren", 64'(wb.rd_wren), 64'd0);
    chk("alu_hold_addr", 64'(wb.rd_addr), 64'd5);
    chk("alu_hold_data", 64'(wb.rd_data), 64'hDEADBEEF);

    // LSU alone takes two edges through the FIFO
    lsu(5'd12, 32'h55);
    step();
    chk("lsu_lat_e1_wren", 64'(wb.rd_wren), 64'd0);
    idle();
    step();
    exp_wr("lsu_lat_e2", 5'd12, 32'h55);
    step();
    chk("lsu_lat_idle", 64'(wb.rd_wren), 64'd0);

    // Contention: ALU addr 3 for three cycles, LSU addr 7 waits
    alu(5'd3, 32'hA0);
    lsu(5'd7, 32'h11);
    step();
    exp_wr("cont_alu0", 5'd3, 32'hA0);
    wb.lsu_valid = 1'b0;
    wb.rs1_addr  = 5'd7;
    #1;
    chk("cont_hazard_fifo", 64'(wb.hazard), 64'd1);
    alu(5'd3, 32'hA1);
    step();
    exp_wr("cont_alu1", 5'd3, 32'hA1);
    alu(5'd3, 32'hA2);
    step();
    exp_wr("cont_alu2", 5'd3, 32'hA2);
    idle();
    step();
    exp_wr("cont_lsu", 5'd7, 32'h11);
    chk("cont_hazard_out", 64'(wb.hazard), 64'd1);
    step();
    chk("cont_idle_wren", 64'(wb.rd_wren), 64'd0);
    chk("cont_idle_hazard", 64'(wb.hazard), 64'd0);
    wb.rs1_addr = 5'd0;

    // Full FIFO under continuous ALU traffic
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_ready_%0d", i), 64'(wb.lsu_ready), 64'd1);
      alu(5'd1, 32'h200 + 32'(i));
      lsu(full_addr[i], full_data[i]);
      step();
      exp_wr($sformatf("full_alu_%0d", i), 5'd1, 32'h200 + 32'(i));
    end
    chk("full_ready_lo", 64'(wb.lsu_ready), 64'd0);
    alu(5'd1, 32'h204);
    lsu(5'd30, 32'hBAD);
    step();
    exp_wr("full_alu_4", 5'd1, 32'h204);
    chk("full_ready_still_lo", 64'(wb.lsu_ready), 64'd0);
    idle();
    step();
    exp_wr("drain0", full_addr[0], full_data[0]);
    chk("drain0_ready", 64'(wb.lsu_ready), 64'd1);
    // push and pop on the same edge
    lsu(5'd24, 32'h104);
    step();
    exp_wr("drain1", full_addr[1], full_data[1]);
    idle();
    step();
    exp_wr("drain2", full_addr[2], full_data[2]);
    step();
    exp_wr("drain3", full_addr[3], full_data[3]);
    step();
    exp_wr("drain4", 5'd24, 32'h104);
    step();
    chk("drain_done_wren", 64'(wb.rd_wren), 64'd0);
    chk("drain_done_ready", 64'(wb.lsu_ready), 64'd1);

    // x0 writes are dropped and never fill the FIFO
    alu(5'd0, 32'hFF);
    lsu(5'd0, 32'hEE);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("x0_wren_%0d", i), 64'(wb.rd_wren), 64'd0);
      chk($sformatf("x0_ready_%0d", i), 64'(wb.lsu_ready), 64'd1);
    end
    idle();
    step();
    chk("x0_no_drain", 64'(wb.rd_wren), 64'd0);

    // Hazard against FIFO entry and registered output
    alu(5'd2, 32'h22);
    lsu(5'd9, 32'h99);
    step();
    idle();
    wb.alu_valid   = 1'b1;
    wb.alu_rd_addr = 5'd2;
    wb.alu_data    = 32'h23;
    wb.rs2_addr    = 5'd9;
    #1;
    chk("haz_rs2_fifo", 64'(wb.hazard), 64'd1);
    wb.rs2_addr = 5'd0;
    #1;
    chk("haz_zero", 64'(wb.hazard), 64'd0);
    wb.rs1_addr = 5'd2;
    #1;
    chk("haz_rs1_out", 64'(wb.hazard), 64'd1);
    wb.rs1_addr = 5'd3;
    #1;
    chk("haz_rs1_miss", 64'(wb.hazard), 64'd0);
    wb.rs1_addr = 5'd0;
    idle();
    step();
    exp_wr("haz_drain", 5'd9, 32'h99);
    step();

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      alu(5'd4, 32'h40);
      lsu(5'd10 + 5'(i), 32'h300 + 32'(i));
      step();
    end
    idle();
    step();
    exp_wr("rmd_pop", 5'd10, 32'h300);
    rst = 1'b1;
    alu(5'd6, 32'h66);
    lsu(5'd13, 32'h313);
    #1;
    chk("rmd_ready_in_rst", 64'(wb.lsu_ready), 64'd0);
    step();
    rst = 1'b0;
    idle();
    wb.rs1_addr = 5'd11;
    #1;
    chk("rmd_wren", 64'(wb.rd_wren), 64'd0);
    chk("rmd_addr", 64'(wb.rd_addr), 64'd0);
    chk("rmd_data", 64'(wb.rd_data), 64'd0);
    chk("rmd_ready", 64'(wb.lsu_ready), 64'd1);
    chk("rmd_hazard", 64'(wb.hazard), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rmd_no_stale_%0d", i), 64'(wb.rd_wren), 64'd0);
    end
    wb.rs1_addr = 5'd0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
